// File: rtl/johnson_counter_param.sv
// Parameterised Johnson (twisted-ring) counter.
// - WIDTH bits of register, 2*WIDTH states per cycle.
// - A prescaler issues one advance every DIV enabled cycles.
// - dir selects counting up or down.
// - A synchronous load takes priority over counting.
// - Any illegal pattern is forced back to zero. That correction is reported by
//   a one-cycle illegal pulse.
// - tc pulses for one cycle after an advance that wraps the step index.
module johnson_counter_param #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en,
    input  logic                           dir,
    input  logic                           load,
    input  logic [WIDTH-1:0]               load_val,
    output logic [WIDTH-1:0]               q,
    output logic [$clog2(2*WIDTH)-1:0]     step,
    output logic                           tc,
    output logic                           illegal
);

    localparam int NSTATES = 2 * WIDTH;
    localparam int SW      = $clog2(NSTATES);
    // Prescaler width; a 1-bit counter that never leaves 0 when DIV == 1.
    localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(NSTATES - 1);

    logic [PW-1:0]     pre_reg;
    logic [WIDTH-1:0]  q_reg;
    logic              tc_reg;
    logic              illegal_reg;

    logic [NSTATES-1:0] hit;
    logic [SW-1:0]      idx [NSTATES];
    logic [SW-1:0]      step_dec;
    logic               legal;

    logic [WIDTH-1:0]  q_up;
    logic [WIDTH-1:0]  q_down;
    logic              wrap_next;

    // One comparator per legal state; at most one can match a given q.
    for (genvar gi = 0; gi < NSTATES; gi++) begin : g_state
        localparam logic [31:0] ONES = (gi <= WIDTH)
                                     ? ((32'd1 << gi) - 32'd1)
                                     : ~((32'd1 << (gi - WIDTH)) - 32'd1);
        localparam logic [WIDTH-1:0] PAT = ONES[WIDTH-1:0];
        assign hit[gi] = (q_reg == PAT);
        assign idx[gi] = hit[gi] ? SW'(gi) : '0;
    end

    // Collapse the one-hot match into a binary step index (illegal -> 0).
    always_comb begin
        step_dec = '0;
        for (int i = 0; i < NSTATES; i++) begin
            step_dec = step_dec | idx[i];
        end
    end

    assign legal  = |hit;
    assign q_up   = {q_reg[WIDTH-2:0], ~q_reg[WIDTH-1]};
    assign q_down = {~q_reg[0], q_reg[WIDTH-1:1]};
    // Wrap happens leaving the last state going up, or leaving state 0 going down.
    assign wrap_next = dir ? (step_dec == '0) : (step_dec == STEP_LAST);

    // State update: reset > load > illegal correction > advance > hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg       <= '0;
            pre_reg     <= '0;
            tc_reg      <= 1'b0;
            illegal_reg <= 1'b0;
        end else if (load) begin
            q_reg       <= load_val;
            pre_reg     <= '0;
            tc_reg      <= 1'b0;
            illegal_reg <= 1'b0;
        end else if (!legal) begin
            q_reg       <= '0;
            pre_reg     <= '0;
            tc_reg      <= 1'b0;
            illegal_reg <= 1'b1;
        end else begin
            illegal_reg <= 1'b0;
            if (en) begin
                if (pre_reg == PRE_LAST) begin
                    pre_reg <= '0;
                    q_reg   <= dir ? q_down : q_up;
                    tc_reg  <= wrap_next;
                end else begin
                    pre_reg <= pre_reg + PW'(1);
                    tc_reg  <= 1'b0;
                end
            end else begin
                tc_reg <= 1'b0;
            end
        end
    end

    assign q       = q_reg;
    assign step    = step_dec;
    assign tc      = tc_reg;
    assign illegal = illegal_reg;

endmodule

// File: tb/tb_johnson_counter_param.sv
// Directed bench for johnson_counter_param.
// Two instances are exercised: WIDTH=4/DIV=1 and WIDTH=4/DIV=3.
// Inputs change 1 time unit after a rising edge.
// Outputs are sampled at that same point, so each edge's result is checked.
module tb_johnson_counter_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance A: DIV = 1
    logic       reset_a, en_a, dir_a, load_a;
    logic [3:0] load_val_a, q_a;
    logic [2:0] step_a;
    logic       tc_a, ill_a;

    // Instance B: DIV = 3
    logic       reset_b, en_b, dir_b, load_b;
    logic [3:0] load_val_b, q_b;
    logic [2:0] step_b;
    logic       tc_b, ill_b;

    johnson_counter_param #(.WIDTH(4), .DIV(1)) dut_a (
        .clk(clk), .reset(reset_a), .en(en_a), .dir(dir_a), .load(load_a),
        .load_val(load_val_a), .q(q_a), .step(step_a), .tc(tc_a), .illegal(ill_a)
    );

    johnson_counter_param #(.WIDTH(4), .DIV(3)) dut_b (
        .clk(clk), .reset(reset_b), .en(en_b), .dir(dir_b), .load(load_b),
        .load_val(load_val_b), .q(q_b), .step(step_b), .tc(tc_b), .illegal(ill_b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] up_q   [8];
    logic [3:0] down_q [8];
    logic [3:0] b_q    [11];
    logic       b_en   [11];

    initial begin
        up_q   = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000, 4'b0000};
        down_q = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
        b_q    = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0011,
                   4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0111};
        b_en   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        reset_a = 1'b0; en_a = 1'b0; dir_a = 1'b0; load_a = 1'b0; load_val_a = 4'b0000;
        reset_b = 1'b0; en_b = 1'b0; dir_b = 1'b0; load_b = 1'b0; load_val_b = 4'b0000;
        #2;
        reset_a = 1'b1;
        reset_b = 1'b1;
        #1;
        check_eq("rst_q",   {28'd0, q_a},    32'd0);
        check_eq("rst_step",{29'd0, step_a}, 32'd0);
        check_eq("rst_tc",  {31'd0, tc_a},   32'd0);
        check_eq("rst_ill", {31'd0, ill_a},  32'd0);
        tick();
        tick();
        reset_a = 1'b0;
        reset_b = 1'b0;

        // ---------------- Instance A: up sweep from reset ----------------
        en_a = 1'b1; dir_a = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq($sformatf("up_q[%0d]", i),    {28'd0, q_a},    {28'd0, up_q[i]});
            check_eq($sformatf("up_step[%0d]", i), {29'd0, step_a}, (i + 1) % 8);
            check_eq($sformatf("up_tc[%0d]", i),   {31'd0, tc_a},   (i == 7) ? 32'd1 : 32'd0);
        end

        // ---------------- Instance A: down sweep from 0000 ----------------
        dir_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check_eq($sformatf("dn_q[%0d]", i),    {28'd0, q_a},    {28'd0, down_q[i]});
            check_eq($sformatf("dn_step[%0d]", i), {29'd0, step_a}, 7 - i);
            check_eq($sformatf("dn_tc[%0d]", i),   {31'd0, tc_a},   (i == 0) ? 32'd1 : 32'd0);
        end

        // ---------------- Instance A: direction change between advances ----
        dir_a = 1'b0;
        tick();
        tick();
        check_eq("dirchg_up", {28'd0, q_a}, 32'h3);
        dir_a = 1'b1;
        tick();
        check_eq("dirchg_dn", {28'd0, q_a}, 32'h1);
        check_eq("dirchg_step", {29'd0, step_a}, 32'd1);

        // ---------------- Instance A: load illegal value, then correction --
        en_a = 1'b0; load_a = 1'b1; load_val_a = 4'b1010;
        tick();
        check_eq("ld_q",    {28'd0, q_a},    32'ha);
        check_eq("ld_step", {29'd0, step_a}, 32'd0);
        check_eq("ld_ill",  {31'd0, ill_a},  32'd0);
        load_a = 1'b0;
        tick();
        check_eq("fix_q",   {28'd0, q_a},   32'd0);
        check_eq("fix_ill", {31'd0, ill_a}, 32'd1);
        check_eq("fix_tc",  {31'd0, tc_a},  32'd0);
        tick();
        check_eq("fix_ill_drop", {31'd0, ill_a}, 32'd0);
        check_eq("fix_q_hold",   {28'd0, q_a},   32'd0);

        // ---------------- Instance A: async reset at 0111 -----------------
        en_a = 1'b1; dir_a = 1'b0;
        tick(); tick(); tick();
        check_eq("pre_ar_q", {28'd0, q_a}, 32'h7);
        en_a = 1'b0;
        #2;
        reset_a = 1'b1;
        #1;
        check_eq("ar_q",    {28'd0, q_a},    32'd0);
        check_eq("ar_step", {29'd0, step_a}, 32'd0);
        check_eq("ar_tc",   {31'd0, tc_a},   32'd0);
        check_eq("ar_ill",  {31'd0, ill_a},  32'd0);
        reset_a = 1'b0;
        tick();
        check_eq("ar_q_post",   {28'd0, q_a},   32'd0);
        check_eq("ar_tc_post",  {31'd0, tc_a},  32'd0);
        check_eq("ar_ill_post", {31'd0, ill_a}, 32'd0);

        // ---------------- Instance B: DIV=3 prescale with en gap ----------
        dir_b = 1'b0;
        for (int i = 0; i < 11; i++) begin
            en_b = b_en[i];
            tick();
            check_eq($sformatf("div3_q[%0d]", i), {28'd0, q_b}, {28'd0, b_q[i]});
        end
        check_eq("div3_step", {29'd0, step_b}, 32'd3);

        // ---------------- Instance B: load on prescale-terminal cycle ------
        en_b = 1'b1; load_b = 1'b1; load_val_b = 4'b1000;
        tick();
        check_eq("b_ld1_q", {28'd0, q_b}, 32'h8);
        load_b = 1'b0;
        tick();
        tick();
        check_eq("b_pre2_q", {28'd0, q_b}, 32'h8);
        load_b = 1'b1;
        tick();
        check_eq("b_ldterm_q",  {28'd0, q_b},  32'h8);
        check_eq("b_ldterm_tc", {31'd0, tc_b}, 32'd0);
        load_b = 1'b0;
        tick();
        check_eq("b_re1_q",  {28'd0, q_b},  32'h8);
        tick();
        check_eq("b_re2_q",  {28'd0, q_b},  32'h8);
        tick();
        check_eq("b_wrap_q",    {28'd0, q_b},    32'h0);
        check_eq("b_wrap_tc",   {31'd0, tc_b},   32'd1);
        check_eq("b_wrap_step", {29'd0, step_b}, 32'd0);
        tick();
        check_eq("b_tc_drop", {31'd0, tc_b}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/johnson_counter_param.md
JOHNSON_COUNTER_PARAM -- requirements
Module: johnson_counter_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving Johnson register width and a 2*WIDTH state cycle; legal range 2..16.
REQ-002 The block SHALL have parameter DIV, default 1, giving the advance prescale ratio in enabled clock cycles; legal range 1..2^16.
REQ-003 The block SHALL have port clk, input, width 1, as the single clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port reset, input, width 1, as the reset: asynchronous, active-high.
REQ-005 The block SHALL have port en, input, width 1, as the count enable.
REQ-006 The block SHALL have port dir, input, width 1, selecting direction: 0 counts up, 1 counts down.
REQ-007 The block SHALL have port load, input, width 1, as the synchronous load strobe.
REQ-008 The block SHALL have port load_val, input, width WIDTH, as the value captured on load.
REQ-009 The block SHALL have port q, output, width WIDTH, as the Johnson register.
REQ-010 The block SHALL have port step, output, width clog2(2*WIDTH), as the binary index of q.
REQ-011 The block SHALL have port tc, output, width 1, as the registered one-cycle wrap pulse.
REQ-012 The block SHALL have port illegal, output, width 1, as the registered one-cycle self-correction pulse.

Function
REQ-013 The block SHALL use the legal-state mapping below; step k, for k from 0 to 2*WIDTH-1:
- k<=WIDTH: low k bits of q set, others clear.
- k>WIDTH: low (k-WIDTH) bits clear, others set.
- Every other q pattern is illegal.
REQ-014 The block SHALL compute up advance as q <= {q[WIDTH-2:0], ~q[WIDTH-1]}, i.e. step+1 mod 2*WIDTH.
REQ-015 The block SHALL compute down advance as q <= {~q[0], q[WIDTH-1:1]}, i.e. step-1 mod 2*WIDTH.
REQ-016 The prescaler SHALL operate as follows:
- Internal counter pre, range 0..DIV-1.
- Increments only on cycles with en=1.
- When en=1 and pre==DIV-1: advance issued, pre <= 0.
- en=0: pre and q hold.
- DIV=1: advance on every enabled cycle.
REQ-017 Per-edge priority SHALL be reset > load > illegal correction > advance > hold.
REQ-018 On load=1: q <= load_val unconditionally (legal or not); pre <= 0; en and dir ignored that cycle; tc <= 0; illegal <= 0.
REQ-019 On an edge with load=0 and q illegal:
- q <= 0, pre <= 0, illegal <= 1 for exactly one cycle, tc <= 0.
- Applies regardless of en.
REQ-020 The block SHALL drive illegal <= 0 on every edge not covered by REQ-019.
REQ-021 tc SHALL be set to 1 for one cycle following an advance that moves step 2*WIDTH-1 -> 0 (up) or 0 -> 2*WIDTH-1 (down); otherwise 0.
REQ-022 step SHALL be a combinational decode of q per REQ-013; illegal q decodes to 0.
REQ-023 A dir change SHALL take effect at the next advance with no extra latency and no state skip.
REQ-024 Changing dir between advances SHALL NOT disturb pre.

Reset
REQ-025 While reset=1, the block SHALL immediately, without waiting for clk, force q=0, pre=0, tc=0, illegal=0, step=0.
REQ-026 On reset release, the first advance SHALL occur DIV enabled cycles after release.
REQ-027 A reset asserted mid-prescale or mid-load SHALL discard the pending operation.

Verification
REQ-028 The bench SHALL cover: WIDTH=4, DIV=1, en=1, dir=0 from reset, 8 edges -> q = 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000; tc=1 only in the cycle q returns to 0000.
REQ-029 The bench SHALL cover: WIDTH=4, DIV=1, dir=1 from 0000 -> q = 1000, 1100, 1110, 1111, 0111, 0011, 0001, 0000; tc=1 in the cycle q=1000; step = 7, 6, ..., 0.
REQ-030 The bench SHALL cover: load=1, load_val=1010 -> q=1010, step=0; next edge with load=0 -> q=0000, illegal=1 for one cycle, even with en=0.
REQ-031 The bench SHALL cover: DIV=3, en=1 -> q advances on every 3rd edge; en dropped for 2 cycles mid-prescale -> advance delayed exactly 2 cycles.
REQ-032 The bench SHALL cover: load=1 with en=1 on a prescale-terminal cycle -> q=load_val, no advance, tc=0, pre restarts from 0.
REQ-033 The bench SHALL cover: reset pulsed asynchronously between clk edges at q=0111 -> q=0000, step=0 before the next clk edge; tc and illegal remain 0.
